// File: rtl/mt6835_pkg.sv
// Shared definitions for the MT6835 burst-read SPI link.
package mt6835_pkg;

    localparam logic [3:0]  CMD_BURST_RD  = 4'b1010;
    localparam logic [3:0]  CMD_SINGLE_RD = 4'b0011;

    localparam logic [11:0] ADDR_ANGLE_H  = 12'h003;
    localparam logic [11:0] ADDR_ANGLE_M  = 12'h004;
    localparam logic [11:0] ADDR_ANGLE_L  = 12'h005;
    localparam logic [11:0] ADDR_CRC      = 12'h006;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_IGNORE
    } state_t;

    // One byte of CRC-8, MSB first; caller supplies the running value.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc,
                                               input logic [7:0] data,
                                               input logic [7:0] poly);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ poly) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/mt6835_spi_in_sync.sv
// Synchronizes CS/SCK/MOSI into the system clock domain and flags their edges.
module spi_in_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cs,
    input  logic i_sck,
    input  logic i_mosi,
    output logic o_cs,
    output logic o_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_cs_fall,
    output logic o_cs_rise
);

    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_prev;
    logic                   r_sck_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cs_sync   <= '1;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_prev   <= 1'b1;
            r_sck_prev  <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
            r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    assign o_cs       = r_cs_sync[SYNC_STAGES-1];
    assign o_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign o_sck_rise =  r_sck_sync[SYNC_STAGES-1] & ~r_sck_prev;
    assign o_sck_fall = ~r_sck_sync[SYNC_STAGES-1] &  r_sck_prev;
    assign o_cs_fall  = ~r_cs_sync[SYNC_STAGES-1]  &  r_cs_prev;
    assign o_cs_rise  =  r_cs_sync[SYNC_STAGES-1]  & ~r_cs_prev;

endmodule

// File: rtl/mt6835_spi_responder.sv
// MT6835 encoder emulator: serves a snapshot of angle/status plus CRC-8 over SPI burst reads.
module mt6835_spi_responder
    import mt6835_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  CRC_POLY    = 8'h07
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        spi_cs,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [20:0] i_angle,
    input  logic [2:0]  i_status,
    input  logic        i_crc_corrupt,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_frame_abort,
    output logic [3:0]  o_cmd,
    output logic [11:0] o_addr,
    output logic        o_cmd_err
);

    logic        w_cs, w_mosi, w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
    state_t      r_state, w_next_state;
    logic [20:0] r_angle;
    logic [2:0]  r_status;
    logic        r_corrupt;
    logic [7:0]  r_crc, w_crc;
    logic [14:0] r_shift;
    logic [3:0]  r_bitcnt;
    logic [15:0] w_cmd_word;
    logic        w_cmd_ok;
    logic [11:0] r_cur_addr, w_rd_addr;
    logic [7:0]  w_rd_byte, r_tx;
    logic [2:0]  r_txcnt;
    logic        r_burst;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_cs       (spi_cs),
        .i_sck      (spi_sck),
        .i_mosi     (spi_mosi),
        .o_cs       (w_cs),
        .o_mosi     (w_mosi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_cs_fall  (w_cs_fall),
        .o_cs_rise  (w_cs_rise)
    );

    assign w_cmd_word = {r_shift, w_mosi};
    assign w_cmd_ok   = (w_cmd_word[15:12] == CMD_BURST_RD) || (w_cmd_word[15:12] == CMD_SINGLE_RD);
    assign w_crc      = crc8_update(crc8_update(crc8_update(8'h00, r_angle[20:13], CRC_POLY),
                                                r_angle[12:5], CRC_POLY),
                                    {r_angle[4:0], r_status}, CRC_POLY);

    // One address port: start address while in CMD, next burst address while in DATA.
    assign w_rd_addr = (r_state == ST_CMD) ? w_cmd_word[11:0] : r_cur_addr + 12'd1;

    always_comb begin
        w_rd_byte = 8'h00;
        case (w_rd_addr)
            ADDR_ANGLE_H: w_rd_byte = r_angle[20:13];
            ADDR_ANGLE_M: w_rd_byte = r_angle[12:5];
            ADDR_ANGLE_L: w_rd_byte = {r_angle[4:0], r_status};
            ADDR_CRC:     w_rd_byte = r_crc ^ {8{r_corrupt}};
            default:      w_rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_cs_fall) w_next_state = ST_CMD;
            ST_CMD: begin
                if (w_cs_rise)
                    w_next_state = ST_IDLE;
                else if (w_sck_rise && r_bitcnt == 4'd15)
                    w_next_state = w_cmd_ok ? ST_DATA : ST_IGNORE;
            end
            ST_DATA:   if (w_cs_rise) w_next_state = ST_IDLE;
            ST_IGNORE: if (w_cs_rise) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_angle    <= '0;
            r_status   <= '0;
            r_corrupt  <= 1'b0;
            r_crc      <= '0;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_cur_addr <= '0;
            r_burst    <= 1'b0;
            r_tx       <= '0;
            r_txcnt    <= '0;
            spi_miso   <= 1'b0;
            o_cmd      <= '0;
            o_addr     <= '0;
            o_cmd_err  <= 1'b0;
            o_frame_done  <= 1'b0;
            o_frame_abort <= 1'b0;
        end else begin
            r_crc         <= w_crc;
            o_frame_done  <= 1'b0;
            o_frame_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    spi_miso <= 1'b0;
                    if (w_cs_fall) begin
                        r_angle   <= i_angle;
                        r_status  <= i_status;
                        r_corrupt <= i_crc_corrupt;
                        r_bitcnt  <= '0;
                        o_cmd_err <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (w_cs_rise) begin
                        o_frame_abort <= 1'b1;
                    end else if (w_sck_rise) begin
                        r_shift  <= w_cmd_word[14:0];
                        r_bitcnt <= r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd15) begin
                            o_cmd      <= w_cmd_word[15:12];
                            o_addr     <= w_cmd_word[11:0];
                            r_cur_addr <= w_cmd_word[11:0];
                            r_burst    <= (w_cmd_word[15:12] == CMD_BURST_RD);
                            r_tx       <= w_rd_byte;
                            r_txcnt    <= '0;
                            if (!w_cmd_ok) o_cmd_err <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_cs_rise) begin
                        o_frame_done <= 1'b1;
                        spi_miso     <= 1'b0;
                    end else if (w_sck_fall) begin
                        spi_miso <= r_tx[7];
                        r_txcnt  <= r_txcnt + 3'd1;
                        if (r_txcnt == 3'd7) begin
                            r_cur_addr <= r_cur_addr + 12'd1;
                            r_tx       <= r_burst ? w_rd_byte : 8'h00;
                        end else begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end
                    end
                end
                ST_IGNORE: begin
                    spi_miso <= 1'b0;
                    if (w_cs_rise) o_frame_done <= 1'b1;
                end
                default: spi_miso <= 1'b0;
            endcase
        end
    end

    assign o_busy = ~w_cs & (r_state != ST_IDLE);

endmodule

// File: doc/mt6835_spi_responder.md
Name: mt6835_spi_responder

Overview:
- Synthesizable SPI slave that emulates the MT6835 magnetic encoder's burst-read angle interface.
- Used as the far-end target for the encoder-reader master, in simulation and in FPGA loopback/HIL builds when no physical sensor is fitted.
- Samples an externally supplied 21-bit angle and 3-bit status at frame start. Serves them as bytes 0x003..0x006 with CRC-8.
- Oversamples SCK/CS/MOSI on the system clock.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for spi_cs/spi_sck/spi_mosi (min 2).
- CRC_POLY, 8'h07, CRC-8 polynomial. Init 0x00, MSB-first, no final XOR.

Ports:
- i_clk  in  1  system clock; must be ≥8x SCK frequency.
- i_rst  in  1  reset; synchronous, active-low.
- spi_cs  in  1  chip select from master, active-low.
- spi_sck  in  1  SPI clock from master; idle level don't-care.
- spi_mosi  in  1  master out.
- spi_miso  out  1  slave out.
- i_angle  in  21  emulated angle.
- i_status  in  3  emulated status bits.
- i_crc_corrupt  in  1  when 1, transmitted CRC byte is inverted (fault injection).
- o_busy  out  1  high while a frame is active (synced CS low).
- o_frame_done  out  1  1-cycle pulse on CS deassert after a complete command.
- o_frame_abort  out  1  1-cycle pulse on CS deassert with fewer than 16 command bits.
- o_cmd  out  4  last received command nibble.
- o_addr  out  12  last received start address.
- o_cmd_err  out  1  sticky until next frame start: unsupported command received.

Behaviour:
- Reset (i_rst=0 at posedge i_clk):
  - spi_miso=0, all o_* = 0, state IDLE.
  - Synchronizers preset to CS=1, SCK=0.
- Edge detection on synchronized signals: sck_rise, sck_fall, cs_fall, cs_rise. Each is asserted for 1 i_clk.
- SPI timing: MOSI sampled on sck_rise; spi_miso updated on sck_fall. MSB first.
- Registers 0x003..0x006 are mapped from the snapshot:
  - 0x003 = angle[20:13]
  - 0x004 = angle[12:5]
  - 0x005 = {angle[4:0], status[2:0]}
  - 0x006 = CRC-8 over bytes 0x003..0x005, XOR 0xFF if i_crc_corrupt was set at snapshot.
- Any other address returns 0x00.
- FSM states:
  - IDLE:
    - spi_miso=0.
    - On cs_fall: snapshot i_angle/i_status/i_crc_corrupt, clear bit counter and o_cmd_err, go CMD.
    - CRC is registered no later than 2 cycles after the snapshot.
  - CMD:
    - Shift 16 bits into cmd register on sck_rise.
    - On the 16th sck_rise, latch o_cmd=bits[15:12] and o_addr=bits[11:0].
    - cmd 4'b1010 (burst read) or 4'b0011 (single read): load byte at addr, go DATA.
    - Any other cmd: set o_cmd_err, go IGNORE.
  - DATA:
    - On each sck_fall, drive the next bit of the current byte on spi_miso.
    - After the 8th bit of a byte:
      - Burst: addr increments, 12-bit wrap 0xFFF->0x000.
      - Single read: next bytes are 0x00.
    - MOSI ignored.
  - IGNORE: spi_miso=0; wait for CS.
- cs_rise in any non-IDLE state → IDLE within 1 cycle, spi_miso=0.
  - o_frame_done pulses if 16 command bits were received (including IGNORE).
  - Otherwise o_frame_abort pulses.
  - A partially shifted data byte is discarded.
- cs_fall and cs_rise never coincide because they come from a single synced signal. SCK edges while CS is high are ignored.
- Reset mid-frame: immediate return to IDLE. No done/abort pulse. Snapshot cleared.
- i_angle changes during a frame do not affect the frame.
- o_busy = synced CS low and state ≠ IDLE.

Decomposition:
- Package mt6835_pkg holds:
  - command constants CMD_BURST_RD=4'b1010, CMD_SINGLE_RD=4'b0011
  - address constants ADDR_ANGLE_H=12'h003 .. ADDR_CRC=12'h006
  - state enum
  - crc8_update function, shared with the reader master
- One sub-module, spi_in_sync: parameterised synchronizer plus rise/fall detection for CS/SCK/MOSI.

Test Plan:
- Burst read: i_angle=21'h012345, i_status=3'b010, command 0xA003, 32 data bits.
  - Expected bytes: 0x09, 0x1A, 0x2A, then CRC matching the bench model.
  - crc8 over all 4 bytes = 0x00; o_frame_done pulses once; o_cmd=0xA, o_addr=0x003.
- Fault injection: same frame with i_crc_corrupt=1.
  - Byte 3 = bit-inverted CRC; residue ≠ 0x00.
- Snapshot: change i_angle to 21'h1FFFFF after cs_fall, mid-command.
  - Returned bytes still encode 0x012345.
  - The next frame returns 0xFF, 0xFF, 0xF8|status.
- Single read and wrap: command 0x3005 returns 0x2A, then 0x00.
  - Burst 0xAFFF: byte at 0xFFF = 0x00; next address wraps to 0x000 and returns 0x00.
- Errors: command 0x5003 → o_cmd_err=1, MISO stays 0, frame_done pulses.
  - CS raised after 9 SCK cycles → o_frame_abort pulses, o_frame_done stays 0.
- Reset mid-frame: assert i_rst during byte 1 → outputs 0, no pulses.
  - The next frame after release returns correct data.
